reg_wr_arbiter: RTL and testbench

//   Round-robin arbiter for the single shared write port of the CPU register bank (D-FF storage).

---
 rtl/reg_wr_arbiter.sv | 131 +++++++++++++
 tb/tb_reg_wr_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_wr_arbiter.sv
// Round-robin arbiter for the single shared write port of the register bank.
// Grants one requester per two-cycle write slot and counts completed writes.
module reg_wr_arbiter #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic [N_REQ-1:0]          REQ,
    input  logic [N_REQ*ADDR_W-1:0]   REQ_ADDR,
    input  logic [N_REQ*DATA_W-1:0]   REQ_DATA,
    output logic [N_REQ-1:0]          GNT,
    output logic                      WE,
    output logic [ADDR_W-1:0]         WADDR,
    output logic [DATA_W-1:0]         WDATA,
    output logic                      BUSY,
    output logic [CNT_W-1:0]          WR_CNT
);

    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [N_REQ-1:0]  gnt_d;
    logic              we_d;
    logic              busy_d;
    logic [ADDR_W-1:0] waddr_d;
    logic [DATA_W-1:0] wdata_d;
    logic [CNT_W-1:0]  cnt_d;

    logic              found;
    logic [PTR_W-1:0]  win;
    logic [ADDR_W-1:0] addr_sel;
    logic [DATA_W-1:0] data_sel;

    // Rotating scan: first set request starting at the priority pointer
    always_comb begin
        int unsigned idx;
        logic [PTR_W-1:0] cand;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        cand  = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            cand = PTR_W'(idx);
            if (!found && REQ[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // Winner's address/data slice
    always_comb begin
        addr_sel = '0;
        data_sel = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (win == PTR_W'(i)) begin
                addr_sel = REQ_ADDR[i*ADDR_W +: ADDR_W];
                data_sel = REQ_DATA[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = '0;
        we_d    = 1'b0;
        busy_d  = 1'b0;
        waddr_d = WADDR;
        wdata_d = WDATA;
        cnt_d   = WR_CNT;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    gnt_d   = N_REQ'(1) << win;
                    we_d    = 1'b1;
                    busy_d  = 1'b1;
                    waddr_d = addr_sel;
                    wdata_d = data_sel;
                    ptr_d   = (32'(win) == N_REQ - 1) ? '0 : win + PTR_W'(1);
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                cnt_d   = WR_CNT + CNT_W'(1);
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            GNT     <= '0;
            WE      <= 1'b0;
            BUSY    <= 1'b0;
            WADDR   <= '0;
            WDATA   <= '0;
            WR_CNT  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            GNT     <= gnt_d;
            WE      <= we_d;
            BUSY    <= busy_d;
            WADDR   <= waddr_d;
            WDATA   <= wdata_d;
            WR_CNT  <= cnt_d;
        end
    end

    a_invariants: assert property (@(posedge CLK) disable iff (!RST_N)
        $onehot0(GNT) && (WE == |GNT) && (BUSY == WE));

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Self-checking bench for reg_wr_arbiter: directed scenarios plus random traffic
// against a round-robin reference model; a 4-bit-counter instance checks wrap.
module tb_reg_wr_arbiter;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [3:0]  REQ;
    logic [11:0] REQ_ADDR;
    logic [31:0] REQ_DATA;
    logic [3:0]  GNT;
    logic        WE;
    logic [2:0]  WADDR;
    logic [7:0]  WDATA;
    logic        BUSY;
    logic [15:0] WR_CNT;

    logic [3:0]  gnt_w;
    logic        we_w;
    logic [2:0]  waddr_w;
    logic [7:0]  wdata_w;
    logic        busy_w;
    logic [3:0]  wr_cnt_w;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int          m_ptr;
    logic        m_busy;
    logic [3:0]  m_gnt;
    logic        m_we;
    logic [2:0]  m_waddr;
    logic [7:0]  m_wdata;
    logic [15:0] m_cnt;

    always #5 CLK = ~CLK;

    reg_wr_arbiter #(.N_REQ(4), .ADDR_W(3), .DATA_W(8), .CNT_W(16)) dut (
        .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA),
        .GNT(GNT), .WE(WE), .WADDR(WADDR), .WDATA(WDATA), .BUSY(BUSY), .WR_CNT(WR_CNT)
    );

    reg_wr_arbiter #(.N_REQ(4), .ADDR_W(3), .DATA_W(8), .CNT_W(4)) dut_w (
        .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA),
        .GNT(gnt_w), .WE(we_w), .WADDR(waddr_w), .WDATA(wdata_w), .BUSY(busy_w), .WR_CNT(wr_cnt_w)
    );

    task automatic model_reset();
        m_ptr = 0; m_busy = 1'b0; m_gnt = '0; m_we = 1'b0;
        m_waddr = '0; m_wdata = '0; m_cnt = '0;
    endtask

    // One write slot = one grant cycle then one blanking cycle
    task automatic model_edge(input logic [3:0] r, input logic [11:0] a, input logic [31:0] d);
        int w;
        bit hit;
        if (m_busy) begin
            m_gnt = '0; m_we = 1'b0; m_busy = 1'b0; m_cnt = m_cnt + 16'd1;
        end else if (r != 4'd0) begin
            w = 0; hit = 0;
            for (int k = 0; k < 4; k++) begin
                if (!hit && r[(m_ptr + k) % 4]) begin
                    w = (m_ptr + k) % 4;
                    hit = 1;
                end
            end
            m_gnt = 4'(1 << w);
            m_we = 1'b1;
            m_busy = 1'b1;
            m_waddr = a[w*3 +: 3];
            m_wdata = d[w*8 +: 8];
            m_ptr = (w + 1) % 4;
        end else begin
            m_gnt = '0; m_we = 1'b0;
        end
    endtask

    task automatic step();
        logic [3:0]  r;
        logic [11:0] a;
        logic [31:0] d;
        logic        rn;
        r = REQ; a = REQ_ADDR; d = REQ_DATA; rn = RST_N;
        @(posedge CLK);
        #1;
        if (!rn) model_reset();
        else model_edge(r, a, d);
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        model_reset();
        repeat (2) step();
        RST_N = 1'b1;
    endtask

    task automatic test_reset();
        REQ = '0; REQ_ADDR = 12'($urandom); REQ_DATA = $urandom;
        do_reset();
        checks++;
        if ({GNT, WE, WADDR, WDATA, BUSY, WR_CNT} !== 33'd0) begin
            failures++;
            $display("FAIL reset: gnt=%b we=%b waddr=%h wdata=%h busy=%b cnt=%h, want all zero",
                     GNT, WE, WADDR, WDATA, BUSY, WR_CNT);
        end
        checks++;
        if (wr_cnt_w !== 4'd0) begin
            failures++;
            $display("FAIL reset_small_cnt: got %h want 0", wr_cnt_w);
        end
    endtask

    task automatic test_single();
        REQ = 4'b0100;
        REQ_ADDR = 12'($urandom); REQ_ADDR[8:6] = 3'd5;
        REQ_DATA = $urandom; REQ_DATA[23:16] = 8'hA5;
        step();
        checks++;
        if (GNT !== 4'b0100 || WE !== 1'b1 || WADDR !== 3'd5 || WDATA !== 8'hA5 || BUSY !== 1'b1) begin
            failures++;
            $display("FAIL single_grant: gnt=%b we=%b waddr=%h wdata=%h busy=%b want 0100 1 5 a5 1",
                     GNT, WE, WADDR, WDATA, BUSY);
        end
        REQ = '0;
        step();
        checks++;
        if (GNT !== 4'b0000 || WE !== 1'b0 || WR_CNT !== 16'd1 || WADDR !== 3'd5 || WDATA !== 8'hA5) begin
            failures++;
            $display("FAIL single_done: gnt=%b we=%b cnt=%h waddr=%h wdata=%h want 0000 0 1 5 a5",
                     GNT, WE, WR_CNT, WADDR, WDATA);
        end
    endtask

    task automatic test_all_req();
        logic [3:0] exp;
        REQ = 4'b1111;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step();
            exp = (i % 2 == 0) ? 4'(1 << ((i / 2) % 4)) : 4'b0000;
            checks++;
            if (GNT !== exp) begin
                failures++;
                $display("FAIL all_req cycle %0d: gnt=%b want %b", i, GNT, exp);
            end
        end
        checks++;
        if (WR_CNT !== 16'd5) begin
            failures++;
            $display("FAIL all_req_cnt: got %0d want 5", WR_CNT);
        end
    endtask

    task automatic test_rr_skip();
        logic [3:0] exp [5];
        exp[0] = 4'b0100; exp[1] = 4'b0000; exp[2] = 4'b1000; exp[3] = 4'b0000; exp[4] = 4'b0001;
        REQ = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            step();
            if (i == 0) REQ = 4'b1001;
            checks++;
            if (GNT !== exp[i]) begin
                failures++;
                $display("FAIL rr_skip step %0d: gnt=%b want %b", i, GNT, exp[i]);
            end
        end
        REQ = '0;
        step();
    endtask

    task automatic test_reset_in_grant();
        REQ = 4'b0010;
        step();
        checks++;
        if (GNT !== 4'b0010) begin
            failures++;
            $display("FAIL pre_reset_grant: gnt=%b want 0010", GNT);
        end
        #2;
        RST_N = 1'b0;
        model_reset();
        #1;
        checks++;
        if (GNT !== 4'b0000 || WE !== 1'b0 || BUSY !== 1'b0 || WR_CNT !== 16'd0) begin
            failures++;
            $display("FAIL async_reset: gnt=%b we=%b busy=%b cnt=%h want 0000 0 0 0", GNT, WE, BUSY, WR_CNT);
        end
        REQ = 4'b1111;
        #2;
        RST_N = 1'b1;
        step();
        checks++;
        if (GNT !== 4'b0001) begin
            failures++;
            $display("FAIL post_reset_grant: gnt=%b want 0001", GNT);
        end
        REQ = '0;
        step();
    endtask

    task automatic test_req_in_grant();
        logic [3:0] seen;
        REQ = 4'b0001;
        step();
        checks++;
        if (GNT !== 4'b0001) begin
            failures++;
            $display("FAIL blank_setup: gnt=%b want 0001", GNT);
        end
        seen = '0;
        REQ = 4'b0010;
        step();
        seen = seen | GNT;
        REQ = '0;
        repeat (2) begin
            step();
            seen = seen | GNT;
        end
        checks++;
        if (seen !== 4'b0000) begin
            failures++;
            $display("FAIL grant_blanking: saw gnt bits %b want 0000", seen);
        end
    endtask

    task automatic test_random();
        logic [32:0] exp;
        for (int i = 0; i < 300; i++) begin
            REQ = 4'($urandom_range(0, 15));
            REQ_ADDR = 12'($urandom);
            REQ_DATA = $urandom;
            step();
            exp = {m_gnt, m_we, m_waddr, m_wdata, m_busy, m_cnt};
            checks++;
            if ({GNT, WE, WADDR, WDATA, BUSY, WR_CNT} !== exp) begin
                failures++;
                $display("FAIL random cycle %0d: gnt=%b we=%b wa=%h wd=%h busy=%b cnt=%0d want %b %b %h %h %b %0d",
                         i, GNT, WE, WADDR, WDATA, BUSY, WR_CNT,
                         m_gnt, m_we, m_waddr, m_wdata, m_busy, m_cnt);
            end
            checks++;
            if (wr_cnt_w !== m_cnt[3:0]) begin
                failures++;
                $display("FAIL small_cnt_wrap cycle %0d: got %0d want %0d", i, wr_cnt_w, m_cnt[3:0]);
            end
            checks++;
            if (!$onehot0(GNT) || WE !== (|GNT) || BUSY !== WE) begin
                failures++;
                $display("FAIL invariant cycle %0d: gnt=%b we=%b busy=%b", i, GNT, WE, BUSY);
            end
        end
        REQ = '0;
    endtask

    initial begin
        RST_N = 1'b0;
        REQ = '0;
        REQ_ADDR = '0;
        REQ_DATA = '0;
        model_reset();
        test_reset();
        test_single();
        test_all_req();
        test_rr_skip();
        test_reset_in_grant();
        test_req_in_grant();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
